alu_wide_seq: RTL and testbench

//  Multi-word add/subtract sequencer; the initiator side of the combinational 16-bit alu.

---
 rtl/alu_wide_seq_pkg.sv | 18 +
 rtl/alu_wide_seq.sv | 158 +++++++++++++++
 tb/tb_alu_wide_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_wide_seq_pkg.sv
// Shared constants for the multi-word add/subtract sequencer and the alu it drives.
package alu_wide_seq_pkg;

  // alu opcodes used by the sequencer (must match the alu's opcode map)
  localparam logic [5:0] ALU_ADD  = 6'h00;
  localparam logic [5:0] ALU_ADDC = 6'h01;

  // sequencer states
  localparam logic [1:0] SEQ_IDLE  = 2'd0;
  localparam logic [1:0] SEQ_ISSUE = 2'd1;
  localparam logic [1:0] SEQ_DONE  = 2'd2;

  // signed overflow of an add: operands agree in sign, result sign differs
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
    add_overflow = (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// Multi-word add/subtract sequencer. Feeds the external 16-bit alu one word per
// cycle, chaining the carry through ALU_ADDC, and collects the result words.
module alu_wide_seq
  import alu_wide_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAXW  = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Req,
  input  logic                  ReqSub,
  input  logic [1:0]            ReqWords,
  input  logic                  ReqCin,
  input  logic [MAXW*WIDTH-1:0] InA,
  input  logic [MAXW*WIDTH-1:0] InB,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Done,
  output logic [MAXW*WIDTH-1:0] Y,
  output logic                  CO,
  output logic                  V,
  output logic                  Z,
  output logic [WIDTH-1:0]      AluA,
  output logic [WIDTH-1:0]      AluB,
  output logic [5:0]            AluOp,
  output logic                  AluCI,
  input  logic [WIDTH-1:0]      AluR,
  input  logic                  AluCO
);

  logic [1:0]            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  sub_q, sub_d;
  logic                  carry_q, carry_d;
  logic [MAXW*WIDTH-1:0] a_q, a_d;
  logic [MAXW*WIDTH-1:0] b_q, b_d;
  logic [MAXW*WIDTH-1:0] y_q, y_d;
  logic                  co_q, co_d;
  logic                  v_q, v_d;
  logic                  z_q, z_d;
  logic [MAXW*WIDTH-1:0] y_cap_s;

  // Drive the alu with the current word while issuing; park it on a plain ADD otherwise
  always_comb begin
    AluA  = '0;
    AluB  = '0;
    AluOp = ALU_ADD;
    AluCI = 1'b0;
    if (state_q == SEQ_ISSUE) begin
      AluA  = a_q[idx_q*WIDTH +: WIDTH];
      AluB  = sub_q ? ~b_q[idx_q*WIDTH +: WIDTH] : b_q[idx_q*WIDTH +: WIDTH];
      AluOp = ALU_ADDC;
      AluCI = carry_q;
    end else begin
      AluA  = '0;
    end
  end

  // Result vector as it will look once the current alu word is captured
  always_comb begin
    y_cap_s = y_q;
    y_cap_s[idx_q*WIDTH +: WIDTH] = AluR;
  end

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
    case (state_q)
      SEQ_IDLE: begin
        if (Req) begin
          state_d = SEQ_ISSUE;
          a_d     = InA;
          b_d     = InB;
          cnt_d   = ReqWords;
          sub_d   = ReqSub;
          // subtraction is A + ~B + 1, so a borrow-in of 1 means carry-in of 0
          carry_d = ReqSub ? ~ReqCin : ReqCin;
          y_d     = '0;
          idx_d   = 2'd0;
          co_d    = 1'b0;
          v_d     = 1'b0;
          z_d     = 1'b0;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_ISSUE: begin
        y_d     = y_cap_s;
        carry_d = AluCO;
        if (idx_q == cnt_q) begin
          state_d = SEQ_DONE;
          co_d    = AluCO;
          v_d     = add_overflow(AluA[WIDTH-1], AluB[WIDTH-1], AluR[WIDTH-1]);
          // inactive words were cleared on accept, so they cannot disturb Z
          z_d     = ~|y_cap_s;
        end else begin
          idx_d   = idx_q + 2'd1;
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset mid-operation discards the result
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= SEQ_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 2'd0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign Ready = (state_q == SEQ_IDLE) && !Rst;
  assign Busy  = (state_q == SEQ_ISSUE);
  assign Done  = (state_q == SEQ_DONE);
  assign Y     = y_q;
  assign CO    = co_q;
  assign V     = v_q;
  assign Z     = z_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq; models the external 16-bit alu inline.
module tb_alu_wide_seq;
  import alu_wide_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        req;
  logic        req_sub;
  logic [1:0]  req_words;
  logic        req_cin;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] y_o;
  logic        co_o;
  logic        v_o;
  logic        z_o;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [5:0]  alu_op;
  logic        alu_ci;
  logic [15:0] alu_r;
  logic        alu_co;

  int n_vec;
  int n_miss;

  alu_wide_seq #(.WIDTH(16), .MAXW(4)) dut (
    .Clk(clk), .Rst(rst), .Req(req), .ReqSub(req_sub), .ReqWords(req_words),
    .ReqCin(req_cin), .InA(in_a), .InB(in_b), .Ready(ready), .Busy(busy),
    .Done(done), .Y(y_o), .CO(co_o), .V(v_o), .Z(z_o), .AluA(alu_a),
    .AluB(alu_b), .AluOp(alu_op), .AluCI(alu_ci), .AluR(alu_r), .AluCO(alu_co)
  );

  // external alu: ADD ignores CI, ADDC adds it
  logic [16:0] alu_sum;
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, (alu_op == ALU_ADDC) ? alu_ci : 1'b0};
  assign alu_r   = alu_sum[15:0];
  assign alu_co  = alu_sum[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // issue one request from IDLE and wait (bounded) for Done
  task automatic do_op(input logic sub, input logic [1:0] words, input logic cin,
                       input logic [63:0] a, input logic [63:0] b,
                       output int dcyc, output logic [63:0] y,
                       output logic co, output logic v, output logic z,
                       output logic op_bad);
    dcyc = -1; y = '0; co = 1'b0; v = 1'b0; z = 1'b0; op_bad = 1'b0;
    req = 1'b1; req_sub = sub; req_words = words; req_cin = cin; in_a = a; in_b = b;
    @(posedge clk); #1;
    req = 1'b0;
    in_a = 64'hDEAD_BEEF_0BAD_F00D;
    in_b = 64'h1234_5678_9ABC_DEF0;
    for (int c = 1; c <= 12; c++) begin
      if (busy && alu_op !== ALU_ADDC) op_bad = 1'b1;
      if (!busy && alu_op !== ALU_ADD) op_bad = 1'b1;
      if (done) begin
        dcyc = c; y = y_o; co = co_o; v = v_o; z = z_o;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; req_sub = 1'b0; req_words = 2'd0; req_cin = 1'b0;
    in_a = '0; in_b = '0;
    @(posedge clk); #1;
    n_vec++; if (ready !== 1'b0) begin n_miss++; $display("FAIL reset_ready_in_rst got=%0b exp=0", ready); end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    n_vec++; if (ready !== 1'b1) begin n_miss++; $display("FAIL reset_ready got=%0b exp=1", ready); end
    n_vec++; if ({busy, done} !== 2'b00) begin n_miss++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    n_vec++; if (y_o !== 64'd0 || {co_o, v_o, z_o} !== 3'b000) begin n_miss++; $display("FAIL reset_result y=%h flags=%b exp y=0 flags=000", y_o, {co_o, v_o, z_o}); end
    n_vec++; if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_op !== ALU_ADD || alu_ci !== 1'b0) begin n_miss++; $display("FAIL reset_alu_drive a=%h b=%h op=%h ci=%b", alu_a, alu_b, alu_op, alu_ci); end
  endtask

  task automatic test_add2();
    int dc; logic [63:0] y; logic co, v, z, bad;
    do_op(1'b0, 2'd1, 1'b0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, dc, y, co, v, z, bad);
    n_vec++; if (dc !== 3) begin n_miss++; $display("FAIL add2_done_cycle got=%0d exp=3", dc); end
    n_vec++; if (y !== 64'h0000_0000_0001_0000) begin n_miss++; $display("FAIL add2_y got=%h exp=0000000000010000", y); end
    n_vec++; if ({co, v, z} !== 3'b000) begin n_miss++; $display("FAIL add2_flags got=%b exp=000", {co, v, z}); end
    n_vec++; if (bad !== 1'b0) begin n_miss++; $display("FAIL add2_aluop got=%b exp=0", bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_add4();
    int dc; logic [63:0] y; logic co, v, z, bad;
    do_op(1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, dc, y, co, v, z, bad);
    n_vec++; if (dc !== 5) begin n_miss++; $display("FAIL add4_done_cycle got=%0d exp=5", dc); end
    n_vec++; if (y !== 64'd0) begin n_miss++; $display("FAIL add4_y got=%h exp=0", y); end
    n_vec++; if ({co, v, z} !== 3'b101) begin n_miss++; $display("FAIL add4_flags got=%b exp=101", {co, v, z}); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub2();
    int dc; logic [63:0] y; logic co, v, z, bad;
    do_op(1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, dc, y, co, v, z, bad);
    n_vec++; if (dc !== 3) begin n_miss++; $display("FAIL sub2_done_cycle got=%0d exp=3", dc); end
    n_vec++; if (y !== 64'h0000_0000_FFFF_FFFF) begin n_miss++; $display("FAIL sub2_y got=%h exp=00000000ffffffff", y); end
    n_vec++; if ({co, v, z} !== 3'b000) begin n_miss++; $display("FAIL sub2_flags got=%b exp=000", {co, v, z}); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub1();
    int dc; logic [63:0] y; logic co, v, z, bad;
    do_op(1'b1, 2'd0, 1'b0, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001, dc, y, co, v, z, bad);
    n_vec++; if (dc !== 2) begin n_miss++; $display("FAIL sub1_done_cycle got=%0d exp=2", dc); end
    n_vec++; if (y !== 64'h0000_0000_0000_7FFF) begin n_miss++; $display("FAIL sub1_y got=%h exp=0000000000007fff", y); end
    n_vec++; if ({co, v, z} !== 3'b110) begin n_miss++; $display("FAIL sub1_flags got=%b exp=110", {co, v, z}); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic seen_done;
    int dc; logic [63:0] y; logic co, v, z, bad;
    seen_done = 1'b0;
    req = 1'b1; req_sub = 1'b0; req_words = 2'd3; req_cin = 1'b1;
    in_a = 64'h0001_0002_0003_0004; in_b = 64'h0010_0020_0030_0040;
    @(posedge clk); #1;
    req = 1'b0;
    if (done) seen_done = 1'b1;
    @(posedge clk); #1;
    if (done) seen_done = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    if (done) seen_done = 1'b1;
    n_vec++; if (ready !== 1'b0) begin n_miss++; $display("FAIL abort_ready_in_rst got=%0b exp=0", ready); end
    rst = 1'b0; #1;
    for (int c = 0; c < 6; c++) begin
      if (done) seen_done = 1'b1;
      if (c == 0) begin
        n_vec++; if (ready !== 1'b1) begin n_miss++; $display("FAIL abort_ready got=%0b exp=1", ready); end
        n_vec++; if (y_o !== 64'd0) begin n_miss++; $display("FAIL abort_y got=%h exp=0", y_o); end
      end
      @(posedge clk); #1;
    end
    n_vec++; if (seen_done !== 1'b0) begin n_miss++; $display("FAIL abort_no_done got=%0b exp=0", seen_done); end
    do_op(1'b0, 2'd0, 1'b0, 64'd3, 64'd4, dc, y, co, v, z, bad);
    n_vec++; if (y !== 64'd7 || dc !== 2) begin n_miss++; $display("FAIL abort_next_add y=%h cyc=%0d exp y=7 cyc=2", y, dc); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ndone; int last; logic bad_gap; logic bad_y; logic bad_ready;
    ndone = 0; last = -1; bad_gap = 1'b0; bad_y = 1'b0; bad_ready = 1'b0;
    req = 1'b1; req_sub = 1'b0; req_words = 2'd0; req_cin = 1'b0;
    in_a = 64'd5; in_b = 64'd6;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if ((busy || done) && ready) bad_ready = 1'b1;
      if (done) begin
        ndone++;
        if (y_o !== 64'd11) bad_y = 1'b1;
        if (last >= 0 && c - last != 3) bad_gap = 1'b1;
        last = c;
      end
    end
    req = 1'b0;
    n_vec++; if (ndone !== 4) begin n_miss++; $display("FAIL b2b_done_count got=%0d exp=4", ndone); end
    n_vec++; if (bad_gap !== 1'b0) begin n_miss++; $display("FAIL b2b_spacing got=%0b exp=0", bad_gap); end
    n_vec++; if (bad_y !== 1'b0) begin n_miss++; $display("FAIL b2b_y got=%0b exp=0", bad_y); end
    n_vec++; if (bad_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_ready_busy got=%0b exp=0", bad_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    test_reset();
    test_add2();
    test_add4();
    test_sub2();
    test_sub1();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
